// File: rtl/half_duplex_pin_ctrl_if.sv
// Request/response and pad-buffer signals of the half-duplex pin controller.
// The controller takes the slave view; the requester and pad model take the master view.
interface half_duplex_pin_ctrl_if #(
  parameter int unsigned TXBITS = 8,
  parameter int unsigned RXBITS = 8
);
  logic              START;
  logic [TXBITS-1:0] TX_DATA;
  logic              BUSY;
  logic              DONE;
  logic [RXBITS-1:0] RX_DATA;
  logic              PAD_I;
  logic              PAD_T;
  logic              PAD_O;

  modport master (
    output START, TX_DATA, PAD_O,
    input  BUSY, DONE, RX_DATA, PAD_I, PAD_T
  );

  modport slave (
    input  START, TX_DATA, PAD_O,
    output BUSY, DONE, RX_DATA, PAD_I, PAD_T
  );
endinterface

// File: rtl/half_duplex_pin_ctrl.sv
// Half-duplex single-pin transactor: shifts a word out MSB first, releases the pin
// for a dead-time turnaround, then samples a reply word MSB first.
module half_duplex_pin_ctrl #(
  parameter int unsigned TXBITS     = 8,
  parameter int unsigned RXBITS     = 8,
  parameter int unsigned TURN       = 2,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input logic                  CLK,
  input logic                  RST,
  half_duplex_pin_ctrl_if.slave bus
);

  // Wide enough for the largest down-count (31) so no phase can wrap.
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {IDLE, TX, TURNA, RX} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TXBITS-1:0] tx_sr_q, tx_sr_d;
  logic [RXBITS-1:0] rx_sr_q, rx_sr_d;
  logic [RXBITS-1:0] rx_data_q, rx_data_d;
  logic              pad_i_q, pad_i_d;
  logic              pad_t_q, pad_t_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [RXBITS-1:0] rx_shift;

  assign rx_shift = RXBITS'({rx_sr_q, bus.PAD_O});

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      pad_i_q   <= IDLE_LEVEL;
      pad_t_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      pad_i_q   <= pad_i_d;
      pad_t_q   <= pad_t_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Outputs are computed for the state being entered, so the pad sees them registered.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    pad_i_d   = pad_i_q;
    pad_t_d   = pad_t_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        pad_t_d = 1'b1;
        pad_i_d = IDLE_LEVEL;
        busy_d  = 1'b0;
        if (bus.START) begin
          state_d = TX;
          cnt_d   = CNT_W'(TXBITS - 1);
          tx_sr_d = TXBITS'({bus.TX_DATA, 1'b0});
          pad_i_d = bus.TX_DATA[TXBITS-1];
          pad_t_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      TX: begin
        if (cnt_q == '0) begin
          state_d = TURNA;
          cnt_d   = CNT_W'(TURN - 1);
          pad_t_d = 1'b1;
          pad_i_d = IDLE_LEVEL;
        end else begin
          cnt_d   = CNT_W'(cnt_q - 1'b1);
          pad_i_d = tx_sr_q[TXBITS-1];
          tx_sr_d = TXBITS'({tx_sr_q, 1'b0});
        end
      end
      TURNA: begin
        if (cnt_q == '0) begin
          state_d = RX;
          cnt_d   = CNT_W'(RXBITS - 1);
          rx_sr_d = '0;
        end else begin
          cnt_d = CNT_W'(cnt_q - 1'b1);
        end
      end
      RX: begin
        rx_sr_d = rx_shift;
        if (cnt_q == '0) begin
          state_d   = IDLE;
          rx_data_d = rx_shift;
          done_d    = 1'b1;
          busy_d    = 1'b0;
        end else begin
          cnt_d = CNT_W'(cnt_q - 1'b1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.RX_DATA = rx_data_q;
  assign bus.PAD_I   = pad_i_q;
  assign bus.PAD_T   = pad_t_q;

endmodule
